// File: rtl/shift_engine_if.sv
//------------------------------------------------------------------------------
// shift_engine_if
//
// Purpose : Bundles the request and result signals of the shift engine so the
//           register-file side (master) and the engine (slave) connect with a
//           single port. The clock CLK and reset clr stay outside the interface.
//
// Parameters
//   N  : data width in bits (N >= 2)
//   CW : width of the shift-amount field
//
// Signals (direction as seen by the master)
//   start   out  request; only acted on while the engine is idle
//   mode    out  shift mode (3 bits), latched at start
//   amt     out  shift count (CW bits), latched at start
//   D       out  parallel load word, bits [N:1]
//   Shiftin out  serial fill bit for LSL/LSR, sampled on every shift edge
//   Qout    in   parallel result, bits [N:1]
//   busy    in   high while an operation is in flight (SHIFT or DONE)
//   done    in   one-cycle completion pulse
//   shout   in   bit that left the word on the most recent shift
//   sticky  in   OR of all bits discarded since start (0 when feature is off)
//------------------------------------------------------------------------------
interface shift_engine_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] amt;
    logic [N:1]    D;
    logic          Shiftin;

    logic [N:1]    Qout;
    logic          busy;
    logic          done;
    logic          shout;
    logic          sticky;

    modport master (
        output start, mode, amt, D, Shiftin,
        input  Qout, busy, done, shout, sticky
    );

    modport slave (
        input  start, mode, amt, D, Shiftin,
        output Qout, busy, done, shout, sticky
    );
endinterface

// File: rtl/shift_engine.sv
//------------------------------------------------------------------------------
// shift_engine
//
// Purpose : Multi-cycle shift engine. Loads an N-bit word and shifts it one bit
//           per clock for a programmed amount in one of five modes (LSL, LSR,
//           ASR, ROL, ROR), then reports completion with a one-cycle done pulse.
//           Used between the register file and the arithmetic units, e.g. for
//           normalisation or serial conversion.
//
// Parameters
//   N  : data width in bits (N >= 2); the bus interface must use the same N
//   CW : shift-amount width; any amount 0..2^CW-1 is legal, including >= N
//
// Ports
//   CLK : rising-edge clock
//   clr : asynchronous active-high reset; aborts any operation without done
//   bus : shift_engine_if.slave (start/mode/amt/D/Shiftin in,
//         Qout/busy/done/shout/sticky out)
//
// Configuration
//   SHIFT_ENGINE_STICKY_EN : when defined, sticky accumulates the OR of every
//   bit discarded by LSL/LSR/ASR since start. When undefined, sticky is tied
//   to 0 and no sticky logic exists.
//
// Timing
//   With E0 the edge that samples start, done is high in the cycle after edge
//   E0+amt; busy is high for amt+1 cycles. An amount of 0 goes straight to DONE.
//   DONE always returns to IDLE, so back-to-back operations need one idle cycle.
//------------------------------------------------------------------------------
module shift_engine #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          clr,
    shift_engine_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Mode encodings; 3'b101..3'b111 are reserved (word holds, counter runs).
    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    state_t        state;
    logic [N:1]    q;
    logic [CW-1:0] cnt;
    logic [2:0]    mode_q;
    logic          shout_q;
    logic          busy_q;
    logic          done_q;

    logic [N:1]    q_next;
    logic          shout_next;
    logic          lossy;      // current mode discards the bit it shifts out

    //--------------------------------------------------------------------------
    // One-bit shift of the held word according to the latched mode.
    //--------------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case, so
    // reserved modes fall through without creating a latch.
    always_comb begin
        q_next     = q;
        shout_next = 1'b0;
        lossy      = 1'b0;
        case (mode_q)
            MODE_LSL: begin
                q_next     = {q[N-1:1], bus.Shiftin};
                shout_next = q[N];
                lossy      = 1'b1;
            end
            MODE_LSR: begin
                q_next     = {bus.Shiftin, q[N:2]};
                shout_next = q[1];
                lossy      = 1'b1;
            end
            MODE_ASR: begin
                q_next     = {q[N], q[N:2]};
                shout_next = q[1];
                lossy      = 1'b1;
            end
            MODE_ROL: begin
                q_next     = {q[N-1:1], q[N]};
                shout_next = q[N];
            end
            MODE_ROR: begin
                q_next     = {q[1], q[N:2]};
                shout_next = q[1];
            end
            default: begin
                // Reserved: word holds and shout reads 0.
            end
        endcase
    end

`ifdef SHIFT_ENGINE_STICKY_EN
    logic sticky_q;
`endif

    //--------------------------------------------------------------------------
    // Control FSM and datapath registers. busy/done are registered alongside
    // the state so the outputs come straight from flops.
    //--------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register sees
    // the pre-edge values of the others (e.g. the shift uses the old q while
    // cnt decrements in the same edge).
    always_ff @(posedge CLK or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            q       <= '0;
            cnt     <= '0;
            mode_q  <= MODE_LSL;
            shout_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_ENGINE_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        q       <= bus.D;
                        cnt     <= bus.amt;
                        mode_q  <= bus.mode;
                        shout_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SHIFT_ENGINE_STICKY_EN
                        sticky_q <= 1'b0;
`endif
                        if (bus.amt == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    q       <= q_next;
                    shout_q <= shout_next;
                    cnt     <= cnt - CW'(1);
`ifdef SHIFT_ENGINE_STICKY_EN
                    if (lossy) begin
                        sticky_q <= sticky_q | shout_next;
                    end
`endif
                    // The edge that takes cnt from 1 to 0 ends the operation.
                    if (cnt == CW'(1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    // start is deliberately ignored here.
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Qout  = q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.shout = shout_q;

`ifdef SHIFT_ENGINE_STICKY_EN
    assign bus.sticky = sticky_q;
`else
    // Without the feature, lossy only matters for sticky; keep it referenced.
    logic unused_lossy;
    assign unused_lossy = lossy;
    assign bus.sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_engine.sv
//------------------------------------------------------------------------------
// tb_shift_engine
//
// Directed bench for shift_engine. The driver issues operations and pushes the
// hand-computed result (word, shout, sticky, done cycle, busy length) into a
// scoreboard queue; an independent monitor pops and compares each time done is
// seen. Expected sticky values are those with SHIFT_ENGINE_STICKY_EN defined,
// masked to 0 when the feature is compiled out.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_engine;

    localparam int N  = 8;
    localparam int CW = 4;

`ifdef SHIFT_ENGINE_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    typedef struct {
        string          name;
        logic [N-1:0]   q;
        logic           shout;
        logic           sticky;
        int             done_cyc;
        int             busy_len;
    } exp_t;

    logic CLK = 1'b0;
    logic clr = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    shift_engine_if #(.N(N), .CW(CW)) bus ();

    shift_engine #(.N(N), .CW(CW)) dut (
        .CLK (CLK),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    //--------------------------------------------------------------------------
    // Monitor: compares every done pulse against the oldest scoreboard entry.
    //--------------------------------------------------------------------------
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (clr) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt = busy_cnt + 1;
            else          busy_cnt = 0;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_qout"},   {24'd0, bus.Qout}, {24'd0, e.q});
                    check({e.name, "_shout"},  {31'd0, bus.shout}, {31'd0, e.shout});
                    check({e.name, "_sticky"}, {31'd0, bus.sticky}, {31'd0, e.sticky & STICKY_ON});
                    check({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    check({e.name, "_busy_len"}, busy_cnt, e.busy_len);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Driver helpers. issue() is entered on a negedge with the engine idle and
    // returns on the negedge after the start-sampling edge.
    //--------------------------------------------------------------------------
    task automatic issue(input string name, input logic [2:0] m, input int a,
                         input logic [N-1:0] d, input logic si,
                         input logic [N-1:0] eq, input logic es, input logic est);
        exp_t e;
        bus.mode    = m;
        bus.amt     = CW'(a);
        bus.D       = d;
        bus.Shiftin = si;
        bus.start   = 1'b1;
        e.name      = name;
        e.q         = eq;
        e.shout     = es;
        e.sticky    = est;
        e.done_cyc  = cyc + 1 + a;
        e.busy_len  = a + 1;
        sb.push_back(e);
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && bus.busy; i++) @(negedge CLK);
        check({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.start   = 1'b0;
        bus.mode    = 3'b000;
        bus.amt     = '0;
        bus.D       = '0;
        bus.Shiftin = 1'b0;

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_qout",   {24'd0, bus.Qout}, 32'h0);
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_done",   {31'd0, bus.done}, 32'd0);
        check("rst_shout",  {31'd0, bus.shout}, 32'd0);
        check("rst_sticky", {31'd0, bus.sticky}, 32'd0);
        clr = 1'b0;
        @(negedge CLK);

        //     name      mode    amt D      Si    Qout   shout sticky
        issue("lsr_b4",  3'b001, 3, 8'hB4, 1'b0, 8'h16, 1'b1, 1'b1); wait_idle("lsr_b4");
        issue("asr_90",  3'b010, 2, 8'h90, 1'b0, 8'hE4, 1'b0, 1'b0); wait_idle("asr_90");
        issue("rol_81",  3'b011, 1, 8'h81, 1'b0, 8'h03, 1'b1, 1'b0); wait_idle("rol_81");
        issue("ror_81",  3'b100, 9, 8'h81, 1'b0, 8'hC0, 1'b1, 1'b0); wait_idle("ror_81");
        issue("lsl_amt0",3'b000, 0, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0); wait_idle("lsl_amt0");
        issue("rsv_101", 3'b101, 2, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0); wait_idle("rsv_101");

        // Second start mid-shift must be ignored (only one done expected).
        issue("lsl_restart", 3'b000, 4, 8'h0F, 1'b1, 8'hFF, 1'b0, 1'b0);
        @(negedge CLK);
        bus.start = 1'b1;
        bus.D     = 8'h00;
        bus.amt   = CW'(1);
        bus.mode  = 3'b001;
        @(negedge CLK);
        bus.start = 1'b0;
        wait_idle("lsl_restart");

        // Abort with clr between edges after two shifts.
        issue("lsr_abort", 3'b001, 6, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("abort_mid_qout", {24'd0, bus.Qout}, 32'h3F);
        #1;
        clr = 1'b1;
        #1;
        check("abort_qout",  {24'd0, bus.Qout}, 32'h0);
        check("abort_busy",  {31'd0, bus.busy}, 32'd0);
        check("abort_done",  {31'd0, bus.done}, 32'd0);
        check("abort_shout", {31'd0, bus.shout}, 32'd0);
        sb.delete();
        @(negedge CLK);
        clr = 1'b0;
        repeat (10) @(negedge CLK);
        check("abort_stay_idle", {31'd0, bus.busy}, 32'd0);

        // Normal operation after the abort.
        issue("lsr_post", 3'b001, 3, 8'hB4, 1'b1, 8'hF6, 1'b1, 1'b1); wait_idle("lsr_post");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
